// File: rtl/core_cfu_pkg.sv
// Shared encodings for the execute-stage control flow unit: result ops, trap causes,
// one-hot cfu_op bit positions and FSM states.
package core_cfu_pkg;

    localparam logic [2:0] CFU_OP_NOP    = 3'd0;
    localparam logic [2:0] CFU_OP_TAKEN  = 3'd1;
    localparam logic [2:0] CFU_OP_IGNORE = 3'd2;
    localparam logic [2:0] CFU_OP_TRAP   = 3'd3;
    localparam logic [2:0] CFU_OP_MRET   = 3'd4;
    localparam logic [2:0] CFU_OP_WFI    = 3'd5;

    localparam logic [6:0] TRAP_IALIGN  = 7'd0;
    localparam logic [6:0] TRAP_IACCESS = 7'd1;
    localparam logic [6:0] TRAP_BREAKPT = 7'd3;
    localparam logic [6:0] TRAP_ECALLM  = 7'd11;

    localparam int OP_BEQ   = 0;
    localparam int OP_BNE   = 1;
    localparam int OP_BLT   = 2;
    localparam int OP_BGE   = 3;
    localparam int OP_BLTU  = 4;
    localparam int OP_BGEU  = 5;
    localparam int OP_J     = 6;
    localparam int OP_JAL   = 7;
    localparam int OP_JALR  = 8;
    localparam int OP_EBRK  = 9;
    localparam int OP_ECALL = 10;
    localparam int OP_MRET  = 11;
    localparam int OP_WFI   = 12;
    localparam int OP_CNT   = 13;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_DONE     = 2'd2,
        ST_WFI_WAIT = 2'd3
    } cfu_state_e;

endpackage

// File: rtl/core_cfu_target.sv
// Combinational branch/jump target with alignment and physical-range checks; zero latency,
// no flow control.
module core_cfu_target #(
    parameter int XLEN    = 64,
    parameter int PADDR_W = 39,
    parameter int IALIGN  = 16
) (
    input  logic            is_jalr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] offset,
    output logic [XLEN-1:0] target,
    output logic            misaligned,
    output logic            non_existent
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    assign base   = is_jalr ? rs1 : pc;
    assign sum    = base + offset;
    // jalr always clears bit 0 of the computed address
    assign target = {sum[XLEN-1:1], sum[0] & ~is_jalr};

    if (IALIGN == 32) begin : g_align32
        assign misaligned = |target[1:0];
    end else begin : g_align16
        assign misaligned = target[0];
    end

    if (PADDR_W < XLEN) begin : g_paddr_chk
        assign non_existent = |target[XLEN-1:PADDR_W];
    end else begin : g_paddr_full
        assign non_existent = 1'b0;
    end

endmodule

// File: rtl/core_pipe_exec_cfu_v2.sv
// Execute-stage control flow unit: resolves branches/jumps/traps and owns the fetch redirect handshake
// (cf_valid held with a stable target until cf_ack). Optional branch prediction via CORE_CFU_BPRED_EN.
module core_pipe_exec_cfu_v2
    import core_cfu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int PADDR_W  = 39,
    parameter int IALIGN   = 16,
    parameter int CFU_OP_W = 3
) (
    input  logic                g_clk,
    input  logic                g_reset,
    input  logic                new_instr,
    input  logic                valid,
    input  logic                irq_pending,
    input  logic                cmp_eq,
    input  logic                cmp_lt,
    input  logic                cmp_ltu,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     npc,
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     offset,
    input  logic [OP_CNT-1:0]   cfu_op,
    output logic                cf_valid,
    input  logic                cf_ack,
    output logic [XLEN-1:0]     cf_target,
    output logic [XLEN-1:0]     new_pc,
    output logic [CFU_OP_W-1:0] new_op,
    output logic                rd_wen,
    output logic [XLEN-1:0]     rd_wdata,
    output logic                trap_raise,
    output logic [6:0]          trap_cause,
    output logic                finished
`ifdef CORE_CFU_BPRED_EN
    ,
    input  logic                pred_taken,
    input  logic [XLEN-1:0]     pred_target,
    output logic                mispredict
`endif
);

    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            non_existent;

    core_cfu_target #(
        .XLEN    (XLEN),
        .PADDR_W (PADDR_W),
        .IALIGN  (IALIGN)
    ) u_target (
        .is_jalr      (cfu_op[OP_JALR]),
        .pc           (pc),
        .rs1          (rs1),
        .offset       (offset),
        .target       (target),
        .misaligned   (misaligned),
        .non_existent (non_existent)
    );

    logic            is_cond;
    logic            cond_taken;
    logic            is_jump;
    logic            eligible;
    logic            addr_trap;
    logic            taken;
    logic            trap;
    logic            wfi_op;
    logic            req;
    logic [XLEN-1:0] req_target;

    cfu_state_e      state_q;
    cfu_state_e      state_d;
    logic [XLEN-1:0] tgt_q;

    assign is_cond    = |cfu_op[OP_BGEU:OP_BEQ];
    assign cond_taken = (cfu_op[OP_BEQ]  &  cmp_eq)  | (cfu_op[OP_BNE]  & ~cmp_eq)
                      | (cfu_op[OP_BLT]  &  cmp_lt)  | (cfu_op[OP_BGE]  & ~cmp_lt)
                      | (cfu_op[OP_BLTU] &  cmp_ltu) | (cfu_op[OP_BGEU] & ~cmp_ltu);
    assign is_jump    = cfu_op[OP_J] | cfu_op[OP_JAL] | cfu_op[OP_JALR];
    assign eligible   = is_jump | cond_taken;
    assign addr_trap  = eligible & (misaligned | non_existent);
    assign taken      = eligible & ~addr_trap;
    assign trap       = valid & (cfu_op[OP_EBRK] | cfu_op[OP_ECALL] | addr_trap);
    assign wfi_op     = valid & cfu_op[OP_WFI] & ~trap;

    assign trap_raise = ~g_reset & trap;
    assign rd_wen     = ~g_reset & valid & ~trap & (cfu_op[OP_JAL] | cfu_op[OP_JALR]);
    assign rd_wdata   = npc;
    assign new_pc     = taken ? target : npc;

`ifdef CORE_CFU_BPRED_EN
    // Only a wrong prediction redirects fetch; a predicted-taken fall-through goes back to npc.
    assign mispredict = valid & ~trap & (is_cond | is_jump)
                      & ((taken != pred_taken) | (taken & (target != pred_target)));
    assign req        = mispredict;
    assign req_target = taken ? target : npc;
`else
    assign req        = valid & ~trap & taken;
    assign req_target = target;
`endif

    always_comb begin
        trap_cause = TRAP_IALIGN;
        if (addr_trap && non_existent) begin
            trap_cause = TRAP_IACCESS;
        end else if (cfu_op[OP_ECALL]) begin
            trap_cause = TRAP_ECALLM;
        end else if (cfu_op[OP_EBRK]) begin
            trap_cause = TRAP_BREAKPT;
        end
    end

    always_comb begin
        new_op = CFU_OP_W'(CFU_OP_NOP);
        if (trap) begin
            new_op = CFU_OP_W'(CFU_OP_TRAP);
        end else if (cfu_op[OP_MRET]) begin
            new_op = CFU_OP_W'(CFU_OP_MRET);
        end else if (cfu_op[OP_WFI]) begin
            new_op = CFU_OP_W'(CFU_OP_WFI);
        end else if (taken) begin
            new_op = CFU_OP_W'(CFU_OP_TAKEN);
        end else if (is_cond) begin
            new_op = CFU_OP_W'(CFU_OP_IGNORE);
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req) begin
                tgt_q <= req_target;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = cf_ack ? ST_DONE : ST_REQ;
                end else if (wfi_op) begin
                    state_d = irq_pending ? ST_DONE : ST_WFI_WAIT;
                end
            end
            ST_REQ:      if (cf_ack)      state_d = ST_DONE;
            ST_WFI_WAIT: if (irq_pending) state_d = ST_DONE;
            ST_DONE:     state_d = ST_DONE;
            default:     state_d = ST_IDLE;
        endcase
        // A new instruction always restarts the unit, aborting any pending request.
        if (new_instr) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        cf_valid  = 1'b0;
        cf_target = tgt_q;
        finished  = 1'b0;
        if (!g_reset) begin
            case (state_q)
                ST_IDLE: begin
                    cf_valid  = req;
                    cf_target = req_target;
                    if (req) begin
                        finished = cf_ack;
                    end else if (wfi_op) begin
                        finished = irq_pending;
                    end else begin
                        finished = valid;
                    end
                end
                ST_REQ: begin
                    cf_valid = ~trap;
                    finished = trap | cf_ack;
                end
                ST_DONE: finished = 1'b1;
                default: finished = 1'b0;
            endcase
        end
    end

endmodule

// File: doc/core_pipe_exec_cfu_v2.md
Name: core_pipe_exec_cfu_v2

Overview:
- Parametrised control flow unit for the execute stage. Resolves conditional branches, jumps, ecall/ebreak, mret and wfi.
- Computes targets and raises alignment/access traps, with alignment selectable for 16-bit or 32-bit instruction sets.
- Owns the control-flow-change handshake to fetch through a registered state machine. Target is held stable while requested; WFI stalls until an interrupt is pending.
- Sits between the decode-driven operand registers and writeback.

Parameters:
- XLEN, 64, data/address width; XL = XLEN-1.
- PADDR_W, 39, implemented physical address bits. Targets with any bit at or above PADDR_W set are non-existent.
- IALIGN, 16, instruction alignment in bits; legal values 16 or 32.
- CFU_OP_W, 3, width of the new_op encoding.

Ports:
- g_clk  in  1  core clock
- g_reset  in  1  synchronous, active-high reset
- new_instr  in  1  new instruction presented this cycle; clears per-instruction state
- valid  in  1  operands valid
- irq_pending  in  1  enabled interrupt pending (wakes WFI)
- cmp_eq / cmp_lt / cmp_ltu  in  1 each  comparator results for rs1 vs rs2
- pc  in  XLEN  current PC
- npc  in  XLEN  next sequential PC
- rs1  in  XLEN  source register 1
- offset  in  XLEN  sign-extended immediate
- cfu_op  in  13  one-hot: beq, bne, blt, bge, bltu, bgeu, j, jal, jalr, ebrk, ecall, mret, wfi
- cf_valid  out  1  control-flow change request
- cf_ack  in  1  fetch accepts request
- cf_target  out  XLEN  request target; stable while cf_valid is high
- new_pc  out  XLEN  next architectural PC
- new_op  out  CFU_OP_W  NOP/TAKEN/IGNORE/TRAP/MRET/WFI
- rd_wen  out  1  link register write enable
- rd_wdata  out  XLEN  link value (npc)
- trap_raise  out  1  trap request
- trap_cause  out  7  trap cause
- finished  out  1  instruction complete

Behaviour:
- Target computation:
  - jalr: target = (rs1 + offset) & ~1.
  - Otherwise: target = pc + offset, modulo 2^XLEN.
- Trap detection:
  - misaligned = target[0] when IALIGN=16; target[1:0]!=0 when IALIGN=32. Evaluated only for taken branches and jumps.
  - non_existent = |target[XL:PADDR_W] when PADDR_W<XLEN; otherwise always 0.
  - trap_raise = valid && (ebrk || ecall || (taken-eligible && (misaligned || non_existent))).
  - Cause priority: IACCESS(1) > ECALLM(11) > BREAKPT(3) > IALIGN(0).
- Taken:
  - Unconditional ops (j, jal, jalr) are taken when not trapping.
  - Conditionals follow RISC-V semantics: bge = !lt, bgeu = !ltu.
  - new_pc = taken ? target : npc.
  - rd_wen = valid && !trap_raise && (jal || jalr).
- FSM states: IDLE, REQ, DONE, WFI_WAIT. Reset state is IDLE.
  - IDLE:
    - taken && valid: cf_valid=1 with combinational target, latched into tgt_q. cf_ack same cycle → DONE and finished=1 this cycle; no ack → REQ.
    - wfi && valid: → WFI_WAIT, unless irq_pending is already high, in which case finished=1 immediately.
  - REQ: cf_valid=1, cf_target=tgt_q. cf_ack → DONE, finished=1.
  - DONE: cf_valid=0, finished=1; hold until new_instr.
  - WFI_WAIT: finished=0; irq_pending → DONE.
- finished is also 1 combinationally for trap_raise, not-taken conditionals, mret and nop-like ops while valid.
- new_instr in any state → IDLE next cycle.
  - new_instr in REQ aborts the request: cf_valid deasserts next cycle.
  - new_instr together with cf_ack: the ack completes the current instruction (finished=1), then the FSM goes to IDLE.
- g_reset has highest priority.
  - Synchronous: on the first edge the FSM goes to IDLE and tgt_q clears to 0.
  - While g_reset is high: cf_valid=0, finished=0, trap_raise=0, rd_wen=0.
- cf_valid never asserts while trap_raise is high.
- cf_target does not change while cf_valid is high and cf_ack is low.

Optional Feature:
- Macro CORE_CFU_BPRED_EN.
- When defined, adds inputs pred_taken (1) and pred_target (XLEN), and output mispredict (1).
  - A request is raised only on mispredict: (taken != pred_taken) || (taken && target != pred_target).
  - A not-taken conditional that was predicted taken raises cf_valid with cf_target = npc.
  - A correctly predicted instruction finishes immediately without entering REQ.
- When not defined, every taken branch or jump requests a change and mispredict is absent.

Decomposition:
- Package core_cfu_pkg:
  - CFU_OP_* encodings: NOP=0, TAKEN=1, IGNORE=2, TRAP=3, MRET=4, WFI=5.
  - TRAP_* cause constants.
  - One-hot op index localparams.
  - FSM state enum.
- Sub-module core_cfu_target: combinational target, misaligned and non-existent checks. Parametrised by XLEN, PADDR_W, IALIGN.

Test Plan:
- beq, cmp_eq=1, pc=0x1000, offset=0x20, ack held low 3 cycles then high → cf_valid for 4 cycles, cf_target=0x1020 stable, finished on the ack cycle, new_op=TAKEN.
- bne, cmp_eq=1 → no cf_valid, new_pc=npc, new_op=IGNORE, finished same cycle.
- IALIGN=32, jal with pc=0x1000, offset=0x6 → trap_raise, cause 0, rd_wen=0, cf_valid=0.
- PADDR_W=39, jalr rs1=0x80_0000_0000, offset=0 → cause 1 (IACCESS).
- wfi with irq_pending low 5 cycles then high → finished only after irq_pending is high; new_op=WFI.
- g_reset asserted while in REQ → cf_valid=0 next cycle; after release, FSM is IDLE and a new jal proceeds normally.
